// File: rtl/wb_regfile_stage.sv
// wb_regfile_stage: writeback stage of the pipelined Y86-64 core.
// Holds the W pipeline register (stall/bubble), a register file with an E and
// an M write port, two combinational decode read ports, W forwarding taps,
// a sticky halt latch and a retired-instruction counter.
// Optional feature macro: WB_BYPASS_EN (read ports write-through the value
// being written this cycle).
module wb_regfile_stage #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 4,
  parameter int CNT_W   = 32,
  parameter int RSP_IDX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_valid,
  input  logic [2:0]        m_stat,
  input  logic [3:0]        m_icode,
  input  logic [DATA_W-1:0] m_valE,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [ADDR_W-1:0] m_dstE,
  input  logic [ADDR_W-1:0] m_dstM,
  input  logic              w_stall,
  input  logic              w_bubble,
  input  logic [ADDR_W-1:0] srcA,
  input  logic [ADDR_W-1:0] srcB,
  output logic [DATA_W-1:0] rvalA,
  output logic [DATA_W-1:0] rvalB,
  output logic [ADDR_W-1:0] w_dstE,
  output logic [ADDR_W-1:0] w_dstM,
  output logic [DATA_W-1:0] w_valE,
  output logic [DATA_W-1:0] w_valM,
  output logic [2:0]        w_stat,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  localparam logic [ADDR_W-1:0] RNONE     = '1;
  localparam int                NREG      = 2**ADDR_W;
  localparam logic [2:0]        STAT_AOK  = 3'd1;
  localparam logic [3:0]        ICODE_NOP = 4'd1;

  logic              w_valid_q, w_valid_d;
  logic [2:0]        w_stat_q,  w_stat_d;
  logic [3:0]        w_icode_q, w_icode_d;
  logic [DATA_W-1:0] w_val_e_q, w_val_e_d;
  logic [DATA_W-1:0] w_val_m_q, w_val_m_d;
  logic [ADDR_W-1:0] w_dst_e_q, w_dst_e_d;
  logic [ADDR_W-1:0] w_dst_m_q, w_dst_m_d;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic wr_ok, e_we, m_we, halt_evt;

  // icode and the stack-pointer index are kept for visibility only; the
  // generic M-over-E rule already gives popq %rsp its required result.
  logic unused_ok;
  assign unused_ok = ^{w_icode_q, RSP_IDX[ADDR_W-1:0]};

  // Write eligibility: the W instruction retires on an edge where it leaves W.
  assign wr_ok    = w_valid_q && (w_stat_q == STAT_AOK) && !halted_q && !w_stall;
  assign e_we     = wr_ok && (w_dst_e_q != RNONE);
  assign m_we     = wr_ok && (w_dst_m_q != RNONE);
  assign halt_evt = w_valid_q && (w_stat_q != STAT_AOK) && !w_stall;

  // W register next value: bubble beats stall beats load.
  always_comb begin
    w_valid_d = w_valid_q;
    w_stat_d  = w_stat_q;
    w_icode_d = w_icode_q;
    w_val_e_d = w_val_e_q;
    w_val_m_d = w_val_m_q;
    w_dst_e_d = w_dst_e_q;
    w_dst_m_d = w_dst_m_q;
    if (w_bubble) begin
      w_valid_d = 1'b0;
      w_stat_d  = STAT_AOK;
      w_icode_d = ICODE_NOP;
      w_val_e_d = '0;
      w_val_m_d = '0;
      w_dst_e_d = RNONE;
      w_dst_m_d = RNONE;
    end else if (!w_stall) begin
      w_valid_d = m_valid;
      w_stat_d  = m_stat;
      w_icode_d = m_icode;
      w_val_e_d = m_valE;
      w_val_m_d = m_valM;
      w_dst_e_d = m_dstE;
      w_dst_m_d = m_dstM;
    end
  end

  // Register file, halt latch and retire counter next values; M write last so it wins.
  always_comb begin
    regs_d    = regs_q;
    halted_d  = halted_q | halt_evt;
    retired_d = retired_q;
    if (e_we) regs_d[w_dst_e_q] = w_val_e_q;
    if (m_we) regs_d[w_dst_m_q] = w_val_m_q;
    if (wr_ok) retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // State registers; reset loads the bubble and clears all architectural state.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_valid_q <= 1'b0;
      w_stat_q  <= STAT_AOK;
      w_icode_q <= ICODE_NOP;
      w_val_e_q <= '0;
      w_val_m_q <= '0;
      w_dst_e_q <= RNONE;
      w_dst_m_q <= RNONE;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      w_valid_q <= w_valid_d;
      w_stat_q  <= w_stat_d;
      w_icode_q <= w_icode_d;
      w_val_e_q <= w_val_e_d;
      w_val_m_q <= w_val_m_d;
      w_dst_e_q <= w_dst_e_d;
      w_dst_m_q <= w_dst_m_d;
      regs_q    <= regs_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
    end
  end

  function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = (a == RNONE) ? '0 : regs_q[a];
`ifdef WB_BYPASS_EN
    if (m_we && (a == w_dst_m_q))      v = w_val_m_q;
    else if (e_we && (a == w_dst_e_q)) v = w_val_e_q;
`endif
    return v;
  endfunction

  // Decode read ports and W forwarding taps.
  always_comb begin
    rvalA   = rd_port(srcA);
    rvalB   = rd_port(srcB);
    w_dstE  = w_valid_q ? w_dst_e_q : RNONE;
    w_dstM  = w_valid_q ? w_dst_m_q : RNONE;
    w_valE  = w_val_e_q;
    w_valM  = w_val_m_q;
    w_stat  = w_valid_q ? w_stat_q : STAT_AOK;
    halted  = halted_q;
    retired = retired_q;
  end

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Scoreboard bench for wb_regfile_stage: stimulus pushes expected values,
// a negedge monitor pops and compares against the DUT outputs.
module tb_wb_regfile_stage;

  localparam int SEL_RA = 0, SEL_RB = 1, SEL_HALT = 2, SEL_RET = 3,
                 SEL_DE = 4, SEL_DM = 5, SEL_STAT = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_valid;
  logic [2:0]  m_stat;
  logic [3:0]  m_icode;
  logic [63:0] m_valE, m_valM;
  logic [3:0]  m_dstE, m_dstM;
  logic        w_stall, w_bubble;
  logic [3:0]  srcA, srcB;
  logic [63:0] rvalA, rvalB, w_valE, w_valM;
  logic [3:0]  w_dstE, w_dstM;
  logic [2:0]  w_stat;
  logic        halted;
  logic [31:0] retired;

  wb_regfile_stage dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_stat(m_stat), .m_icode(m_icode),
    .m_valE(m_valE), .m_valM(m_valM), .m_dstE(m_dstE), .m_dstM(m_dstM),
    .w_stall(w_stall), .w_bubble(w_bubble), .srcA(srcA), .srcB(srcB),
    .rvalA(rvalA), .rvalB(rvalB), .w_dstE(w_dstE), .w_dstM(w_dstM),
    .w_valE(w_valE), .w_valM(w_valM), .w_stat(w_stat), .halted(halted),
    .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  exp_t e;
  logic [63:0] act;

  // Monitor: compare every queued expectation at the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        SEL_RA:   act = rvalA;
        SEL_RB:   act = rvalB;
        SEL_HALT: act = {63'd0, halted};
        SEL_RET:  act = {32'd0, retired};
        SEL_DE:   act = {60'd0, w_dstE};
        SEL_DM:   act = {60'd0, w_dstM};
        default:  act = {61'd0, w_stat};
      endcase
      tests++;
      if (act !== e.val) begin
        fails++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.val);
      end
    end
  end

  task automatic expect_val(input string name, input int sel, input logic [63:0] val);
    exp_t x;
    x.name = name; x.sel = sel; x.val = val;
    sb.push_back(x);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] st, input logic [3:0] ic,
                       input logic [3:0] de, input logic [63:0] ve,
                       input logic [3:0] dm, input logic [63:0] vm);
    m_valid = v; m_stat = st; m_icode = ic;
    m_dstE = de; m_valE = ve; m_dstM = dm; m_valM = vm;
  endtask

  task automatic idle();
    drive(1'b0, 3'd1, 4'd1, 4'hF, 64'd0, 4'hF, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset held for two edges with garbage on the memory-stage inputs.
    rst = 1'b1; w_stall = 1'b1; w_bubble = 1'b0; srcA = 4'd0; srcB = 4'd0;
    drive(1'b1, 3'd1, 4'd3, 4'd3, 64'hDEAD_BEEF, 4'd7, 64'hCAFE);
    cycle(); cycle();
    expect_val("rst_halted", SEL_HALT, 64'd0);
    expect_val("rst_retired", SEL_RET, 64'd0);
    expect_val("rst_dstE", SEL_DE, 64'd15);
    expect_val("rst_dstM", SEL_DM, 64'd15);
    expect_val("rst_stat", SEL_STAT, 64'd1);
    rst = 1'b0; w_stall = 1'b0; idle();
    for (int i = 0; i < 16; i++) begin
      srcA = 4'(i); srcB = 4'(15 - i);
      expect_val($sformatf("rst_regA%0d", i), SEL_RA, 64'd0);
      expect_val($sformatf("rst_regB%0d", 15 - i), SEL_RB, 64'd0);
      cycle();
    end

    // irmovq to reg2, then bubble.
    drive(1'b1, 3'd1, 4'd3, 4'd2, 64'h1234, 4'hF, 64'd0);
    cycle();
    idle(); w_bubble = 1'b1; srcA = 4'd2;
    expect_val("irm_tap_dstE", SEL_DE, 64'd2);
    expect_val("irm_tap_dstM", SEL_DM, 64'd15);
`ifdef WB_BYPASS_EN
    expect_val("irm_reg2_same", SEL_RA, 64'h1234);
`else
    expect_val("irm_reg2_same", SEL_RA, 64'd0);
`endif
    cycle();
    w_bubble = 1'b0;
    expect_val("irm_reg2", SEL_RA, 64'h1234);
    expect_val("irm_retired", SEL_RET, 64'd1);
    expect_val("bubble_dstE", SEL_DE, 64'd15);
    cycle();

    // popq %rsp: both ports target reg4, M wins.
    drive(1'b1, 3'd1, 4'hB, 4'd4, 64'h100, 4'd4, 64'hBEEF);
    cycle();
    idle();
    cycle();
    srcA = 4'd4;
    expect_val("pop_reg4", SEL_RA, 64'hBEEF);
    expect_val("pop_retired", SEL_RET, 64'd2);
    cycle();

    // Two different destinations in one retire.
    drive(1'b1, 3'd1, 4'd5, 4'd7, 64'h77, 4'd8, 64'h88);
    cycle();
    idle();
    cycle();
    srcA = 4'd7; srcB = 4'd8;
    expect_val("dual_reg7", SEL_RA, 64'h77);
    expect_val("dual_reg8", SEL_RB, 64'h88);
    expect_val("dual_retired", SEL_RET, 64'd3);
    cycle();

    // Stall for three edges: no write until release, counted once.
    drive(1'b1, 3'd1, 4'd2, 4'd3, 64'h55, 4'hF, 64'd0);
    cycle();
    idle(); w_stall = 1'b1; srcA = 4'd3;
    for (int k = 0; k < 3; k++) begin
      expect_val($sformatf("stall%0d_reg3", k), SEL_RA, 64'd0);
      expect_val($sformatf("stall%0d_retired", k), SEL_RET, 64'd3);
      cycle();
    end
    w_stall = 1'b0;
`ifdef WB_BYPASS_EN
    expect_val("rel_reg3_same", SEL_RA, 64'h55);
`else
    expect_val("rel_reg3_same", SEL_RA, 64'd0);
`endif
    cycle();
    expect_val("rel_reg3", SEL_RA, 64'h55);
    expect_val("rel_retired", SEL_RET, 64'd4);
    cycle();
    expect_val("rel_retired_once", SEL_RET, 64'd4);
    cycle();

    // Write-through check on reg6.
    drive(1'b1, 3'd1, 4'd3, 4'd6, 64'hAA, 4'hF, 64'd0);
    cycle();
    idle(); srcA = 4'd6;
`ifdef WB_BYPASS_EN
    expect_val("byp_reg6_same", SEL_RA, 64'hAA);
`else
    expect_val("byp_reg6_same", SEL_RA, 64'd0);
`endif
    cycle();
    expect_val("byp_reg6_next", SEL_RA, 64'hAA);
    expect_val("byp_retired", SEL_RET, 64'd5);
    cycle();

    // HLT retires, then a would-be write to reg5 is suppressed.
    drive(1'b1, 3'd2, 4'd0, 4'd1, 64'hDEAD, 4'hF, 64'd0);
    cycle();
    drive(1'b1, 3'd1, 4'd3, 4'd5, 64'h9, 4'hF, 64'd0);
    expect_val("hlt_wstat", SEL_STAT, 64'd2);
    expect_val("hlt_pre_halted", SEL_HALT, 64'd0);
    cycle();
    idle(); srcB = 4'd5;
    expect_val("hlt_halted", SEL_HALT, 64'd1);
    expect_val("hlt_retired", SEL_RET, 64'd5);
    expect_val("hlt_reg5_same", SEL_RB, 64'd0);
    cycle();
    srcA = 4'd1; srcB = 4'd5;
    expect_val("hlt_reg1", SEL_RA, 64'd0);
    expect_val("hlt_reg5", SEL_RB, 64'd0);
    expect_val("hlt_retired_frozen", SEL_RET, 64'd5);
    expect_val("hlt_sticky", SEL_HALT, 64'd1);
    cycle();

    // Reset clears halt, counter and registers.
    rst = 1'b1;
    cycle();
    rst = 1'b0; srcA = 4'd2; srcB = 4'd4;
    expect_val("rst2_halted", SEL_HALT, 64'd0);
    expect_val("rst2_retired", SEL_RET, 64'd0);
    expect_val("rst2_reg2", SEL_RA, 64'd0);
    expect_val("rst2_reg4", SEL_RB, 64'd0);
    cycle();
    cycle();

    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
